fft_reorder_buf: RTL
====================

Name: fft_reorder_buf

Overview:
Parametrised frame buffer placed between the FFT input stage and the butterfly core. It accepts one N-point frame (N = 2^LOG2N) over a req/ans handshake and stores it with optional bit-reversed addressing. It then streams the frame out in natural address order over a second req/ans handshake, which yields the bit-reversed sample order the core expects. It generalises the fixed 32-point, 16-bit, always-bit-reversed buffering with proper flow control on both sides, a selectable mode, and frame-completion signalling.

Parameters:
DATA_W, 16, sample width in bits (complex data packed by the caller).
LOG2N, 5, log2 of frame length; N = 2^LOG2N, legal range 2..10.
BIT_REV, 1, 1 = write address is the bit-reversed sample index; 0 = natural-order pass-through buffer.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  synchronous, active-high reset.
req_i  input  1  upstream offers a sample on data_i.
ans_o  output  1  block accepts a sample; a transfer occurs on a cycle where req_i && ans_o.
data_i  input  DATA_W  input sample.
req_o  output  1  block offers a sample on data_o.
ans_i  input  1  downstream accepts; a transfer occurs on a cycle where req_o && ans_i.
data_o  output  DATA_W  output sample, valid while req_o = 1.
busy  output  1  high in LOAD or DRAIN.
frame_done  output  1  one-cycle pulse after the last output transfer of a frame.

Behaviour:
- Storage: N x DATA_W register array. Write counter wcnt and read counter rcnt, each LOG2N bits.
- Reset (rst = 1 at a clock edge, any state):
  - state <= IDLE.
  - wcnt, rcnt <= 0.
  - ans_o, req_o, busy, frame_done <= 0.
  - Array contents are not cleared.
  - Reset in the middle of a frame discards the partial frame.
- State machine (registered; ans_o, req_o and busy are decoded from the registered state):
  - IDLE: ans_o = 0, req_o = 0. If req_i = 1, go to LOAD on the next cycle. The first sample is not consumed in IDLE.
  - LOAD: ans_o = 1, req_o = 0.
    - On each transfer: mem[addr] <= data_i and wcnt <= wcnt + 1.
    - addr = BIT_REV ? reverse(wcnt) : wcnt, where reverse mirrors all LOG2N bits.
    - When req_i = 0, nothing changes (gaps are allowed).
    - On the transfer with wcnt = N-1, go to DRAIN. wcnt wraps to 0, and ans_o is 0 from the next cycle.
  - DRAIN: req_o = 1, ans_o = 0, data_o = mem[rcnt] (combinational read).
    - On each transfer, rcnt <= rcnt + 1.
    - While ans_i = 0, data_o and rcnt hold stable.
    - On the transfer with rcnt = N-1, go to IDLE. rcnt wraps to 0 and frame_done pulses high for exactly the following cycle.
- Latency: first output is offered on the cycle after the last input transfer. Minimum frame turnaround is 2N+2 cycles (1 IDLE cycle + N loads + N drains + 1 IDLE).
- data_o is 0 whenever req_o = 0.
- req_i held high during DRAIN is ignored (ans_o = 0), so no sample is lost. The next frame starts from IDLE.
- No overflow or underflow is possible: input is refused outside LOAD, and output is withheld outside DRAIN.
- Simultaneous events:
  - rst has priority over any transfer in the same cycle.
  - In IDLE, frame_done and a new req_i may coincide; the IDLE -> LOAD transition proceeds normally.

Test Plan:
1. Defaults (LOG2N=5, BIT_REV=1): req_i held high, data_i = 0..31 on consecutive accepted cycles, ans_i = 1 → data_o sequence 0,16,8,24,4,20,12,28,2,...,31. frame_done pulses once, 1 cycle after the 32nd output.
2. BIT_REV=0, LOG2N=3: input 0..7 → output 0..7 unchanged. busy is high for 16 cycles.
3. LOG2N=3, BIT_REV=1, with req_i deasserted every other cycle during LOAD → output 0,4,2,6,1,5,3,7. No sample is duplicated or dropped.
4. Backpressure: ans_i low for 3 cycles after output #5 → data_o holds value #5 stable and req_o stays 1. The remaining sequence continues intact.
5. Reset mid-LOAD after 10 samples (rst=1 for 1 cycle) → next cycle ans_o = 0 and state is IDLE. A fresh full frame then reorders correctly with no residue from the aborted frame's count.
6. Back-to-back frames with req_i held high through DRAIN: frame 2 data 100..131 is accepted only after frame 1 completes → output 100,116,108,....

Source files
------------

// File: rtl/fft_reorder_buf.sv
// fft_reorder_buf: single-frame reorder buffer between the FFT input stage
// and the butterfly core. A frame is written with optional bit-reversed
// addressing and read back in natural address order.
//
// Handshake (both sides): the producer raises its req while the payload is
// valid, the consumer raises ans when it can take it, and one transfer happens
// on every rising edge where req && ans are both high. Neither side may make
// its req depend combinationally on the other side's ans.
module fft_reorder_buf #(
    parameter int DATA_W  = 16,
    parameter int LOG2N   = 5,
    parameter int BIT_REV = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_i,
    output logic              ans_o,
    input  logic [DATA_W-1:0] data_i,
    output logic              req_o,
    input  logic              ans_i,
    output logic [DATA_W-1:0] data_o,
    output logic              busy,
    output logic              frame_done,
    output logic [1:0]        dbg_state
);

    localparam int N = 1 << LOG2N;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        DRAIN = 2'd2
    } state_t;

    state_t            state;
    logic [LOG2N-1:0]  wcnt;
    logic [LOG2N-1:0]  rcnt;
    logic [LOG2N-1:0]  waddr;
    logic [DATA_W-1:0] mem [N];
    logic              in_xfer;
    logic              out_xfer;

    assign in_xfer   = req_i & ans_o;
    assign out_xfer  = req_o & ans_i;
    assign dbg_state = state;

    // Write address: the sample index, mirrored across all LOG2N bits in bit-reverse mode.
    always_comb begin
        waddr = wcnt;
        if (BIT_REV != 0) begin
            for (int b = 0; b < LOG2N; b++) begin
                waddr[b] = wcnt[LOG2N-1-b];
            end
        end
    end

    // Sample storage; contents survive reset, only the counters are cleared.
    always_ff @(posedge clk) begin
        if (!rst && in_xfer) begin
            mem[waddr] <= data_i;
        end
    end

    // Read port is combinational on rcnt and forced to zero outside DRAIN.
    assign data_o = req_o ? mem[rcnt] : '0;

    // Frame sequencer: IDLE waits for an offer, LOAD fills N samples, DRAIN empties them.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            wcnt       <= '0;
            rcnt       <= '0;
            ans_o      <= 1'b0;
            req_o      <= 1'b0;
            busy       <= 1'b0;
            frame_done <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            case (state)
                IDLE: begin
                    // The first offered sample is only observed here, not consumed.
                    if (req_i) begin
                        state <= LOAD;
                        ans_o <= 1'b1;
                        busy  <= 1'b1;
                    end
                end
                LOAD: begin
                    if (in_xfer) begin
                        wcnt <= wcnt + 1'b1;
                        if (wcnt == LOG2N'(N - 1)) begin
                            state <= DRAIN;
                            ans_o <= 1'b0;
                            req_o <= 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_xfer) begin
                        rcnt <= rcnt + 1'b1;
                        if (rcnt == LOG2N'(N - 1)) begin
                            state      <= IDLE;
                            req_o      <= 1'b0;
                            busy       <= 1'b0;
                            frame_done <= 1'b1;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                    ans_o <= 1'b0;
                    req_o <= 1'b0;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule
